// File: rtl/ext_pkg.sv
// Shared definitions for the MIPS extension stage: operation codes,
// skid-buffer occupancy states and the byte-offset width helper.
package ext_pkg;

  typedef enum logic [2:0] {
    EXT_SEXT = 3'd0,
    EXT_ZEXT = 3'd1,
    EXT_LUI  = 3'd2,
    EXT_LB   = 3'd3,
    EXT_LBU  = 3'd4,
    EXT_LH   = 3'd5,
    EXT_LHU  = 3'd6,
    EXT_WORD = 3'd7
  } ext_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  // Width of a byte offset within one DATA_W word.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_lane_sel.sv
// Combinational immediate/load-lane extraction and extension.
// Produces the final {err, data} so buffer entries hold finished results.
module ext_lane_sel
  import ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int BIG_ENDIAN = 0,
  localparam int OFF_W     = off_w(DATA_W)
) (
  input  ext_mode_e         i_mode,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [DATA_W-1:0] i_word,
  input  logic [OFF_W-1:0]  i_offset,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  localparam int NB = DATA_W / 8;
  localparam int NH = DATA_W / 16;

  logic [OFF_W-1:0] w_byte_idx;
  logic [OFF_W-2:0] w_half_idx;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  // Big-endian mirrors the lane index so offset 0 addresses the top lane.
  always_comb begin
    if (BIG_ENDIAN != 0) begin
      w_byte_idx = OFF_W'(NB - 1) - i_offset;
      w_half_idx = (OFF_W-1)'(NH - 1) - i_offset[OFF_W-1:1];
    end else begin
      w_byte_idx = i_offset;
      w_half_idx = i_offset[OFF_W-1:1];
    end
  end

  assign w_byte = 8'(i_word >> {w_byte_idx, 3'b000});
  assign w_half = 16'(i_word >> {w_half_idx, 4'b0000});

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_err  = 1'b0;
    o_data = '0;
    case (i_mode)
      EXT_SEXT: o_data = DATA_W'(signed'(i_imm));
      EXT_ZEXT: o_data = DATA_W'(i_imm);
      EXT_LUI:  o_data = DATA_W'(i_imm) << (DATA_W - IMM_W);
      EXT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      EXT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      EXT_LH, EXT_LHU: begin
        if (i_offset[0]) begin
          o_err = 1'b1;
        end else if (i_mode == EXT_LH) begin
          o_data = {{(DATA_W-16){w_half[15]}}, w_half};
        end else begin
          o_data = {{(DATA_W-16){1'b0}}, w_half};
        end
      end
      EXT_WORD: o_data = i_word;
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit.sv
// Pipelined extension stage: lane extraction on the input side feeding a
// 2-entry (output + skid) buffer with registered in_ready.
module ext_unit
  import ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int BIG_ENDIAN = 0,
  parameter int TAG_W      = 5,
  localparam int OFF_W     = off_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  occ_state_e        r_state, w_next_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic [TAG_W-1:0]  r_out_tag, r_skid_tag;
  logic              r_out_err, r_skid_err;

  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_err;
  logic              w_in_xfer, w_out_xfer;
  logic              w_load_out_in, w_load_out_skid, w_load_skid;

  ext_lane_sel #(
    .DATA_W     (DATA_W),
    .IMM_W      (IMM_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_sel (
    .i_mode   (ext_mode_e'(in_mode)),
    .i_imm    (in_imm),
    .i_word   (in_word),
    .i_offset (in_offset),
    .o_err    (w_sel_err),
    .o_data   (w_sel_data)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != TWO);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (w_in_xfer) w_next_state = ONE;
      ONE: begin
        if (w_in_xfer && !w_out_xfer)      w_next_state = TWO;
        else if (!w_in_xfer && w_out_xfer) w_next_state = EMPTY;
      end
      TWO:     if (w_out_xfer) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
    if (flush) w_next_state = EMPTY;
  end

  always_comb begin
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (!flush) begin
      case (r_state)
        EMPTY: w_load_out_in = w_in_xfer;
        ONE: begin
          w_load_out_in = w_in_xfer && w_out_xfer;
          w_load_skid   = w_in_xfer && !w_out_xfer;
        end
        TWO:     w_load_out_skid = w_out_xfer;
        default: ;
      endcase
    end
  end

  // Datapath registers are reset too: outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_err   <= 1'b0;
      r_skid_data <= '0;
      r_skid_tag  <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_out_in) begin
        r_out_data <= w_sel_data;
        r_out_tag  <= in_tag;
        r_out_err  <= w_sel_err;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
        r_out_tag  <= r_skid_tag;
        r_out_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_tag  <= in_tag;
        r_skid_err  <= w_sel_err;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_ext_unit.sv
// Directed bench for ext_unit: one little-endian and one big-endian
// instance share stimulus; expected values are hand-computed constants.
module tb_ext_unit;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_mode;
  logic [15:0] in_imm;
  logic [31:0] in_word;
  logic [1:0]  in_offset;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        be_in_ready, be_out_valid, be_out_err;
  logic [31:0] be_out_data;
  logic [4:0]  be_out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ext_unit #(.DATA_W(32), .IMM_W(16), .BIG_ENDIAN(0), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm),
    .in_word(in_word), .in_offset(in_offset), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  ext_unit #(.DATA_W(32), .IMM_W(16), .BIG_ENDIAN(1), .TAG_W(5)) dut_be (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(be_in_ready), .in_mode(in_mode), .in_imm(in_imm),
    .in_word(in_word), .in_offset(in_offset), .in_tag(in_tag),
    .out_valid(be_out_valid), .out_ready(out_ready), .out_data(be_out_data),
    .out_tag(be_out_tag), .out_err(be_out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ext_mode_e mode, input logic [15:0] imm,
                       input logic [31:0] word, input logic [1:0] off,
                       input logic [4:0] tag);
    in_valid  = 1'b1;
    in_mode   = mode;
    in_imm    = imm;
    in_word   = word;
    in_offset = off;
    in_tag    = tag;
  endtask

  // One request with out_ready=1; result checked in the following cycle.
  task automatic vec(input string name, input ext_mode_e mode, input logic [15:0] imm,
                     input logic [31:0] word, input logic [1:0] off, input logic [4:0] tag,
                     input logic [31:0] exp_le, input logic [31:0] exp_be, input logic exp_err);
    drive(mode, imm, word, off, tag);
    step();
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_le"}, 64'(out_data), 64'(exp_le));
    check({name, "_be"}, 64'(be_out_data), 64'(exp_be));
    check({name, "_err"}, 64'({out_err, be_out_err}), 64'({exp_err, exp_err}));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    step();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_imm = '0; in_word = '0; in_offset = '0; in_tag = '0;

    #12;
    check("rst_out_valid", 64'({out_valid, be_out_valid}), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tag_err", 64'({out_tag, out_err}), 64'(0));
    check("rst_in_ready", 64'({in_ready, be_in_ready}), 64'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Immediates
    vec("sext",   EXT_SEXT, 16'h8001, 32'h0,        2'd0, 5'd3, 32'hFFFF8001, 32'hFFFF8001, 1'b0);
    vec("zext",   EXT_ZEXT, 16'h8001, 32'h0,        2'd1, 5'd4, 32'h00008001, 32'h00008001, 1'b0);
    vec("lui",    EXT_LUI,  16'h8001, 32'h0,        2'd3, 5'd5, 32'h80010000, 32'h80010000, 1'b0);
    vec("sext_p", EXT_SEXT, 16'h7FFF, 32'h0,        2'd0, 5'd6, 32'h00007FFF, 32'h00007FFF, 1'b0);
    // Loads on 80FF7F01; BE mirrors the lane index
    vec("lb2",    EXT_LB,   16'h0, 32'h80FF7F01, 2'd2, 5'd7,  32'hFFFFFFFF, 32'h0000007F, 1'b0);
    vec("lbu2",   EXT_LBU,  16'h0, 32'h80FF7F01, 2'd2, 5'd8,  32'h000000FF, 32'h0000007F, 1'b0);
    vec("lb0",    EXT_LB,   16'h0, 32'h80FF7F01, 2'd0, 5'd9,  32'h00000001, 32'hFFFFFF80, 1'b0);
    vec("lh2",    EXT_LH,   16'h0, 32'h80FF7F01, 2'd2, 5'd10, 32'hFFFF80FF, 32'h00007F01, 1'b0);
    vec("lhu0",   EXT_LHU,  16'h0, 32'h80FF7F01, 2'd0, 5'd11, 32'h00007F01, 32'h000080FF, 1'b0);
    vec("lhu1",   EXT_LHU,  16'h0, 32'h80FF7F01, 2'd1, 5'd12, 32'h00000000, 32'h00000000, 1'b1);
    vec("lh3",    EXT_LH,   16'h0, 32'h80FF7F01, 2'd3, 5'd13, 32'h00000000, 32'h00000000, 1'b1);
    vec("word",   EXT_WORD, 16'h0, 32'h80FF7F01, 2'd3, 5'd14, 32'h80FF7F01, 32'h80FF7F01, 1'b0);

    // Backpressure: A and B accepted, C refused while stalled
    out_ready = 1'b0;
    drive(EXT_SEXT, 16'h1234, 32'h0, 2'd0, 5'd20);
    step();
    check("bp_a_valid", 64'(out_valid), 64'(1));
    check("bp_a_ready", 64'(in_ready), 64'(1));
    drive(EXT_ZEXT, 16'hF00F, 32'h0, 2'd0, 5'd21);
    step();
    check("bp_b_ready", 64'({in_ready, be_in_ready}), 64'(0));
    check("bp_b_hold", 64'(out_data), 64'(32'h00001234));
    drive(EXT_LUI, 16'hAAAA, 32'h0, 2'd0, 5'd22);
    step();
    check("bp_c_ready", 64'(in_ready), 64'(0));
    check("bp_c_hold", 64'({out_tag, out_data}), 64'({5'd20, 32'h00001234}));
    step();
    check("bp_c_hold2", 64'({out_valid, out_tag}), 64'({1'b1, 5'd20}));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_b_out", 64'({out_valid, out_tag, out_data}), 64'({1'b1, 5'd21, 32'h0000F00F}));
    check("bp_ready_back", 64'(in_ready), 64'(1));
    step();
    check("bp_drained", 64'(out_valid), 64'(0));

    // Throughput: 10 back-to-back, one result per cycle, no bubbles
    for (int i = 0; i < 10; i++) begin
      drive(EXT_WORD, 16'h0, 32'h01010101 * i, 2'd0, 5'(i));
      step();
      check($sformatf("tp_%0d", i), 64'({out_valid, in_ready, out_tag, out_data}),
            64'({1'b1, 1'b1, 5'(i), 32'h01010101 * i}));
    end
    in_valid = 1'b0;
    step();
    check("tp_drained", 64'(out_valid), 64'(0));

    // Flush in TWO with a simultaneous request
    out_ready = 1'b0;
    drive(EXT_SEXT, 16'h0001, 32'h0, 2'd0, 5'd25);
    step();
    drive(EXT_SEXT, 16'h0002, 32'h0, 2'd0, 5'd26);
    step();
    check("fl_in_two", 64'(in_ready), 64'(0));
    drive(EXT_SEXT, 16'h0003, 32'h0, 2'd0, 5'd27);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'({out_valid, be_out_valid}), 64'(0));
    check("fl_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || be_out_valid) seen++;
      step();
    end
    check("fl_no_result", 64'(seen), 64'(0));

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(EXT_LUI, 16'hBEEF, 32'h0, 2'd0, 5'd30);
    step();
    drive(EXT_LUI, 16'hCAFE, 32'h0, 2'd0, 5'd31);
    step();
    check("ar_pre_valid", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'({out_valid, be_out_valid}), 64'(0));
    check("ar_outputs", 64'({out_tag, out_err, out_data}), 64'(0));
    check("ar_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_after", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
